// File: rtl/load_store_reservation_station_pkg.sv
// Shared reservation-station entry layout and default widths.
// The ALU reservation station reuses this same layout.
package load_store_reservation_station_pkg;

    localparam int RS_XLEN  = 64;
    localparam int RS_ROB_W = 8;

    typedef struct packed {
        logic                valid;
        logic                pend_1st;
        logic [RS_ROB_W-1:0] tag_1st;
        logic [RS_XLEN-1:0]  val_1st;
        logic                pend_2nd;
        logic [RS_ROB_W-1:0] tag_2nd;
        logic [RS_XLEN-1:0]  val_2nd;
        logic [RS_XLEN-1:0]  offset;
        logic [RS_ROB_W-1:0] rob_index;
    } rs_entry_t;

    function automatic logic rs_entry_ready(input rs_entry_t e);
        return e.valid && !e.pend_1st && !e.pend_2nd;
    endfunction

    // Resolve any pending operand whose producer is on the CDB this cycle.
    function automatic rs_entry_t rs_snoop(
        input rs_entry_t           e,
        input logic                cdb_v,
        input logic [RS_ROB_W-1:0] cdb_tag,
        input logic [RS_XLEN-1:0]  cdb_val
    );
        rs_entry_t r;
        r = e;
        if (cdb_v && e.pend_1st && (e.tag_1st == cdb_tag)) begin
            r.val_1st  = cdb_val;
            r.pend_1st = 1'b0;
        end
        if (cdb_v && e.pend_2nd && (e.tag_2nd == cdb_tag)) begin
            r.val_2nd  = cdb_val;
            r.pend_2nd = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_store_reservation_station_select.sv
// Oldest-ready picker: lowest set bit of the ready vector wins.
module rs_oldest_ready_select #(
    parameter int RS_DEPTH = 4,
    parameter int IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0] ready_i,
    output logic [RS_DEPTH-1:0] onehot_o,
    output logic [IDX_W-1:0]    index_o,
    output logic                found_o
);

    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        found_o  = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                index_o     = IDX_W'(i);
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_store_reservation_station.sv
// Load/store reservation station: collapsing queue (slot 0 oldest) with CDB
// wakeup, feeding the address calculator through one registered output stage.
module load_store_reservation_station
    import load_store_reservation_station_pkg::*;
#(
    // XLEN and ROB_INDEX_WIDTH must match the package entry layout.
    parameter int XLEN            = RS_XLEN,
    parameter int ROB_INDEX_WIDTH = RS_ROB_W,
    parameter int RS_DEPTH        = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [XLEN-1:0]            issue_1st_reg,
    input  logic                       issue_1st_pending,
    input  logic [ROB_INDEX_WIDTH-1:0] issue_1st_tag,
    input  logic [XLEN-1:0]            issue_2nd_reg,
    input  logic                       issue_2nd_pending,
    input  logic [ROB_INDEX_WIDTH-1:0] issue_2nd_tag,
    input  logic [XLEN-1:0]            issue_address,
    input  logic [ROB_INDEX_WIDTH-1:0] issue_ROB_index,
    input  logic                       cdb_valid,
    input  logic [ROB_INDEX_WIDTH-1:0] cdb_ROB_index,
    input  logic [XLEN-1:0]            cdb_value,
    output logic                       dispatch_valid,
    input  logic                       dispatch_ready,
    output logic [XLEN-1:0]            dispatch_1st_reg,
    output logic [XLEN-1:0]            dispatch_2nd_reg,
    output logic [XLEN-1:0]            dispatch_address,
    output logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,
    input  logic                       flush
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    rs_entry_t                  slots_q [RS_DEPTH];
    rs_entry_t                  slots_d [RS_DEPTH];
    rs_entry_t                  shift_src [RS_DEPTH+1];
    rs_entry_t                  issue_entry;
    logic [CNT_W-1:0]           count_q, count_d;

    logic                       out_valid_q, out_valid_d;
    logic [XLEN-1:0]            out_1st_q, out_1st_d;
    logic [XLEN-1:0]            out_2nd_q, out_2nd_d;
    logic [XLEN-1:0]            out_addr_q, out_addr_d;
    logic [ROB_INDEX_WIDTH-1:0] out_rob_q, out_rob_d;

    logic [RS_DEPTH-1:0]        ready_vec;
    logic [RS_DEPTH-1:0]        sel_onehot;
    logic [IDX_W-1:0]           sel_idx;
    logic                       sel_found;
    logic [IDX_W-1:0]           wr_idx;
    logic                       issue_fire;
    logic                       load_out;

    assign issue_ready = (count_q < CNT_W'(RS_DEPTH));
    assign issue_fire  = issue_valid && issue_ready;
    assign load_out    = (!out_valid_q || dispatch_ready) && sel_found;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_vec[i] = rs_entry_ready(slots_q[i]);
        end
    end

    rs_oldest_ready_select #(
        .RS_DEPTH (RS_DEPTH),
        .IDX_W    (IDX_W)
    ) u_select (
        .ready_i  (ready_vec),
        .onehot_o (sel_onehot),
        .index_o  (sel_idx),
        .found_o  (sel_found)
    );

    // An op issued alongside its producer's broadcast is written already resolved.
    always_comb begin
        issue_entry           = '0;
        issue_entry.valid     = 1'b1;
        issue_entry.pend_1st  = issue_1st_pending;
        issue_entry.tag_1st   = issue_1st_tag;
        issue_entry.val_1st   = issue_1st_reg;
        issue_entry.pend_2nd  = issue_2nd_pending;
        issue_entry.tag_2nd   = issue_2nd_tag;
        issue_entry.val_2nd   = issue_2nd_reg;
        issue_entry.offset    = issue_address;
        issue_entry.rob_index = issue_ROB_index;
        issue_entry = rs_snoop(issue_entry, cdb_valid, cdb_ROB_index, cdb_value);
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            shift_src[i] = rs_snoop(slots_q[i], cdb_valid, cdb_ROB_index, cdb_value);
        end
        shift_src[RS_DEPTH] = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            slots_d[i] = (load_out && (IDX_W'(i) >= sel_idx)) ? shift_src[i+1] : shift_src[i];
        end
        // The new op lands just above the last occupied slot after any collapse.
        wr_idx = IDX_W'(count_q - CNT_W'(load_out));
        if (issue_fire) begin
            slots_d[wr_idx] = issue_entry;
        end
        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(load_out);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_1st_d   = out_1st_q;
        out_2nd_d   = out_2nd_q;
        out_addr_d  = out_addr_q;
        out_rob_d   = out_rob_q;
        if (load_out) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (sel_onehot[i]) begin
                    out_1st_d  = slots_q[i].val_1st;
                    out_2nd_d  = slots_q[i].val_2nd;
                    out_addr_d = slots_q[i].offset;
                    out_rob_d  = slots_q[i].rob_index;
                end
            end
        end else if (dispatch_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_1st_q   <= '0;
            out_2nd_q   <= '0;
            out_addr_q  <= '0;
            out_rob_q   <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_1st_q   <= out_1st_d;
            out_2nd_q   <= out_2nd_d;
            out_addr_q  <= out_addr_d;
            out_rob_q   <= out_rob_d;
        end
    end

    assign dispatch_valid     = out_valid_q;
    assign dispatch_1st_reg   = out_1st_q;
    assign dispatch_2nd_reg   = out_2nd_q;
    assign dispatch_address   = out_addr_q;
    assign dispatch_ROB_index = out_rob_q;

endmodule
